vc_read_scheduler: RTL and testbench
====================================

Name: vc_read_scheduler

Overview:
Sequences reads from the VC_NUM per-VC circular_buffer instances of one router input port towards the crossbar/link. It performs wormhole packet locking and round-robin arbitration among VCs, and tracks downstream credits per VC. Each cycle it asserts the read_i strobe of at most one buffer.

Parameters:
VC_NUM, 2, number of virtual channels (one circular_buffer each); must be ≥2.
BUFFER_SIZE, 8, downstream per-VC buffer depth; initial credit count per VC.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low; state returns to reset values immediately when rst=0.
is_empty_i  input  VC_NUM  is_empty_o of each VC buffer.
flit_label_i  input  VC_NUM x flit_label_t  flit_label field of each buffer's head-of-queue flit (data_o); valid only when the matching is_empty_i=0.
credit_valid_i  input  1  downstream returns one credit this cycle.
credit_vc_i  input  VC_SIZE  VC id of the returned credit.
read_o  output  VC_NUM  one-hot read strobe to each buffer's read_i; all zero when no grant.
valid_o  output  1  OR of read_o; the flit on the selected data_o is forwarded this cycle.
vc_sel_o  output  VC_SIZE  index of the granted VC; holds its last value when valid_o=0.
err_o  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset values: read_o=0, valid_o=0, vc_sel_o=0, err_o=0. FSM=IDLE, rr_ptr=0, lock_vc=0, credit[v]=BUFFER_SIZE for all v.
- Credit counters are $clog2(BUFFER_SIZE)+1 bits wide.
- Eligibility of VC v: is_empty_i[v]=0 and credit[v]>0.
- read_o, valid_o and vc_sel_o are combinational (Mealy) from registered state plus inputs. Zero-cycle grant latency: a flit is popped on the same clk edge where read_o is high.
- FSM IDLE:
  - Candidates are eligible VCs whose label is HEAD or HEADTAIL.
  - Grant the first candidate searching rr_ptr, rr_ptr+1, ... mod VC_NUM.
  - On grant of HEAD: next state LOCKED, lock_vc=v.
  - On grant of HEADTAIL: stay in IDLE.
  - On any grant, rr_ptr <= (v+1) mod VC_NUM.
  - An eligible VC showing BODY or TAIL is not granted and sets err_o.
- FSM LOCKED:
  - Only lock_vc may be granted, when it is eligible. Other VCs are never granted, even when lock_vc is stalled (empty or zero credit).
  - Granted BODY: stay LOCKED.
  - Granted TAIL: go to IDLE, rr_ptr <= (lock_vc+1) mod VC_NUM.
  - Locked VC showing HEAD or HEADTAIL: no grant, err_o set, FSM stays LOCKED.
- Credits:
  - A grant on v decrements credit[v].
  - credit_valid_i increments credit[credit_vc_i].
  - Both on the same VC in the same cycle: net unchanged.
  - A credit return when the counter already equals BUFFER_SIZE is dropped and sets err_o.
  - A credit_vc_i ≥ VC_NUM is ignored and sets err_o.
  - A credit returned in cycle t only enables a grant in cycle t+1; eligibility uses the registered count.
- Reset mid-packet: lock is abandoned, FSM=IDLE and credits are restored to BUFFER_SIZE. The team guarantees buffers and the downstream link are reset together.
- Throughput: with credits available, one flit per cycle, including back-to-back packets from different VCs. Example: TAIL on VC0 in cycle t, HEAD on VC1 in cycle t+1.

Test Plan:
1. Reset with VC0 holding HEADTAIL -> read_o=0 while rst=0. First cycle after release: read_o=01, vc_sel_o=0, credit[0]=7.
2. VC0 holds HEAD,BODY,TAIL; VC1 holds HEAD,TAIL, all queued -> grants VC0,VC0,VC0,VC1,VC1 on consecutive cycles; no VC1 grant while VC0 is locked; err_o=0.
3. Both VCs continuously present HEADTAIL -> grants alternate 0,1,0,1 starting from VC0 after reset.
4. BUFFER_SIZE=8, VC0 streams a long packet with no credit returns -> exactly 8 grants, then read_o=0. One credit_valid_i with credit_vc_i=0 -> exactly one further grant on the next cycle.
5. VC1 head-of-queue is BODY while FSM=IDLE -> no grant to VC1, err_o=1 and remains 1 until rst=0.
6. Credit return on VC0 with credit[0]=8 -> counter stays 8, err_o=1. Grant plus credit return on VC0 in the same cycle -> counter unchanged.

Source files
------------

// File: rtl/vc_read_scheduler.sv
// Per-input-port VC read scheduler: wormhole locking, round-robin arbitration
// among VCs and downstream credit tracking; drives one buffer read strobe per cycle.
package vc_read_scheduler_pkg;
    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;
endpackage

module vc_read_scheduler
    import vc_read_scheduler_pkg::*;
#(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int VC_SIZE     = $clog2(VC_NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VC_NUM-1:0]       is_empty_i,
    input  flit_label_t [VC_NUM-1:0] flit_label_i,
    input  logic                    credit_valid_i,
    input  logic [VC_SIZE-1:0]      credit_vc_i,
    output logic [VC_NUM-1:0]       read_o,
    output logic                    valid_o,
    output logic [VC_SIZE-1:0]      vc_sel_o,
    output logic                    err_o
);

    localparam int CW = $clog2(BUFFER_SIZE) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_SIZE);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [VC_SIZE-1:0] rr_ptr_q, rr_ptr_d;
    logic [VC_SIZE-1:0] lock_vc_q, lock_vc_d;
    logic [VC_SIZE-1:0] vc_sel_q, vc_sel_d;
    logic [CW-1:0]      credit_q [VC_NUM];
    logic [CW-1:0]      credit_d [VC_NUM];
    logic               err_q, err_d;

    logic [VC_NUM-1:0]  eligible;
    logic [VC_NUM-1:0]  credit_inc;
    logic [VC_NUM-1:0]  credit_dec;
    logic [VC_SIZE-1:0] cand;
    logic               grant;
    logic [VC_SIZE-1:0] grant_vc;
    logic               proto_err;
    logic               credit_err;

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            eligible[v] = !is_empty_i[v] && (credit_q[v] != '0);
        end
    end

    // Grants are suppressed while reset is held so no buffer is popped during reset.
    always_comb begin
        grant     = 1'b0;
        grant_vc  = '0;
        proto_err = 1'b0;
        cand      = '0;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_vc_d = lock_vc_q;
        if (rst) begin
            if (state_q == IDLE) begin
                for (int i = 0; i < VC_NUM; i++) begin
                    cand = VC_SIZE'((int'(rr_ptr_q) + i) % VC_NUM);
                    if (eligible[cand]) begin
                        if (flit_label_i[cand] == BODY || flit_label_i[cand] == TAIL) begin
                            proto_err = 1'b1;
                        end else if (!grant) begin
                            grant    = 1'b1;
                            grant_vc = cand;
                        end
                    end
                end
                if (grant) begin
                    rr_ptr_d = VC_SIZE'((int'(grant_vc) + 1) % VC_NUM);
                    if (flit_label_i[grant_vc] == HEAD) begin
                        state_d   = LOCKED;
                        lock_vc_d = grant_vc;
                    end
                end
            end else if (eligible[lock_vc_q]) begin
                case (flit_label_i[lock_vc_q])
                    BODY: begin
                        grant    = 1'b1;
                        grant_vc = lock_vc_q;
                    end
                    TAIL: begin
                        grant    = 1'b1;
                        grant_vc = lock_vc_q;
                        state_d  = IDLE;
                        rr_ptr_d = VC_SIZE'((int'(lock_vc_q) + 1) % VC_NUM);
                    end
                    default: proto_err = 1'b1;
                endcase
            end
        end
    end

    // A simultaneous grant and credit return on one VC cancel out, so that case can never overflow.
    always_comb begin
        credit_err = credit_valid_i && (int'(credit_vc_i) >= VC_NUM);
        for (int v = 0; v < VC_NUM; v++) begin
            credit_inc[v] = credit_valid_i && (int'(credit_vc_i) == v);
            credit_dec[v] = grant && (int'(grant_vc) == v);
            credit_d[v]   = credit_q[v];
            if (credit_inc[v] && !credit_dec[v]) begin
                if (credit_q[v] == CREDIT_MAX) begin
                    credit_err = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end else if (credit_dec[v] && !credit_inc[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end
        end
        err_d    = err_q | proto_err | credit_err;
        vc_sel_d = grant ? grant_vc : vc_sel_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_vc_q <= '0;
            vc_sel_q  <= '0;
            err_q     <= 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= CREDIT_MAX;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            vc_sel_q  <= vc_sel_d;
            err_q     <= err_d;
            for (int v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign read_o   = grant ? (VC_NUM'(1) << grant_vc) : '0;
    assign valid_o  = grant;
    assign vc_sel_o = vc_sel_d;
    assign err_o    = err_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Self-checking bench for vc_read_scheduler: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vc_read_scheduler;
    import vc_read_scheduler_pkg::*;

    localparam int VC_NUM = 2;
    localparam int BS     = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [VC_NUM-1:0]        is_empty_i;
    flit_label_t [VC_NUM-1:0] flit_label_i;
    logic                     credit_valid_i;
    logic [0:0]               credit_vc_i;
    logic [VC_NUM-1:0]        read_o;
    logic                     valid_o;
    logic [0:0]               vc_sel_o;
    logic                     err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Per-VC buffer contents and the reference scheduler state.
    flit_label_t q0[$];
    flit_label_t q1[$];
    bit m_locked;
    int m_lock, m_rr, m_sel;
    int m_cred[VC_NUM];
    bit m_err;

    typedef struct {
        logic [1:0]  empty;
        flit_label_t lab0;
        flit_label_t lab1;
        logic        cv;
        logic        cvc;
        logic [1:0]  exp_read;
        logic        exp_sel;
        logic        exp_err;
    } vec_t;
    vec_t tbl[17];

    vc_read_scheduler #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BS)) dut (
        .clk(clk), .rst(rst), .is_empty_i(is_empty_i), .flit_label_i(flit_label_i),
        .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i),
        .read_o(read_o), .valid_o(valid_o), .vc_sel_o(vc_sel_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int q_size(int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    function automatic flit_label_t q_front(int v);
        if (q_size(v) == 0) return HEAD;
        return (v == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_push(int v, flit_label_t l);
        if (v == 0) q0.push_back(l);
        else        q1.push_back(l);
    endtask

    task automatic push_packet(int v, int bodies);
        if (bodies < 0) begin
            q_push(v, HEADTAIL);
        end else begin
            q_push(v, HEAD);
            for (int i = 0; i < bodies; i++) q_push(v, BODY);
            q_push(v, TAIL);
        end
    endtask

    task automatic drive_from_queues(input bit cv, input int cvc);
        for (int v = 0; v < VC_NUM; v++) begin
            is_empty_i[v]   = (q_size(v) == 0);
            flit_label_i[v] = q_front(v);
        end
        credit_valid_i = cv;
        credit_vc_i    = cvc[0];
    endtask

    // Reset clears buffers and link together; outputs must be quiet while rst is low.
    task automatic apply_reset(input bit preload_ht);
        rst = 1'b0;
        m_locked = 0; m_lock = 0; m_rr = 0; m_sel = 0; m_err = 0;
        for (int v = 0; v < VC_NUM; v++) m_cred[v] = BS;
        q0.delete();
        q1.delete();
        if (preload_ht) q0.push_back(HEADTAIL);
        drive_from_queues(1'b0, 0);
        #1;
        check("rst_read", read_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_sel", vc_sel_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_read_hold", read_o, 0);
        rst = 1'b1;
    endtask

    // One cycle: present queue heads, compare against the model, then clock and pop.
    task automatic step(input bit cv, input int cvc, output int got);
        int g;
        bit ev_err;
        logic [1:0] rd;
        drive_from_queues(cv, cvc);
        #1;
        g = -1;
        ev_err = 0;
        if (!m_locked) begin
            for (int k = 0; k < VC_NUM; k++) begin
                int v;
                v = (m_rr + k) % VC_NUM;
                if (q_size(v) > 0 && m_cred[v] > 0) begin
                    if (q_front(v) == HEAD || q_front(v) == HEADTAIL) begin
                        if (g < 0) g = v;
                    end else begin
                        ev_err = 1;
                    end
                end
            end
        end else if (q_size(m_lock) > 0 && m_cred[m_lock] > 0) begin
            if (q_front(m_lock) == BODY || q_front(m_lock) == TAIL) g = m_lock;
            else ev_err = 1;
        end
        check("read_o", read_o, (g >= 0) ? (1 << g) : 0);
        check("valid_o", valid_o, (g >= 0) ? 1 : 0);
        check("vc_sel_o", vc_sel_o, (g >= 0) ? g : m_sel);
        check("err_o", err_o, m_err);
        rd = read_o;
        got = rd[0] ? 0 : (rd[1] ? 1 : -1);
        @(posedge clk);
        if (g >= 0) begin
            m_sel = g;
            m_cred[g]--;
            if (!m_locked) begin
                m_rr = (g + 1) % VC_NUM;
                if (q_front(g) == HEAD) begin
                    m_locked = 1;
                    m_lock = g;
                end
            end else if (q_front(g) == TAIL) begin
                m_locked = 0;
                m_rr = (m_lock + 1) % VC_NUM;
            end
        end
        if (cv) begin
            if (cvc >= VC_NUM)        ev_err = 1;
            else if (cvc == g)        m_cred[cvc]++;
            else if (m_cred[cvc] == BS) ev_err = 1;
            else                      m_cred[cvc]++;
        end
        m_err = m_err | ev_err;
        if (rd[0] && q0.size() > 0) void'(q0.pop_front());
        if (rd[1] && q1.size() > 0) void'(q1.pop_front());
        #1;
    endtask

    initial begin
        int got;
        int grants;
        int order[5];

        tbl[0]  = '{2'b11, HEAD,     HEAD,     1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, HEADTAIL, HEADTAIL, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, HEADTAIL, HEADTAIL, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, HEADTAIL, HEADTAIL, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[4]  = '{2'b11, HEAD,     HEAD,     1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, HEAD,     HEADTAIL, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, HEAD,     HEADTAIL, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, HEAD,     HEADTAIL, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, BODY,     HEADTAIL, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, TAIL,     HEAD,     1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{2'b00, HEADTAIL, HEAD,     1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[11] = '{2'b00, HEADTAIL, TAIL,     1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[12] = '{2'b10, HEADTAIL, HEAD,     1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[13] = '{2'b01, HEAD,     BODY,     1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[14] = '{2'b11, HEAD,     HEAD,     1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        tbl[15] = '{2'b10, HEADTAIL, HEAD,     1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
        tbl[16] = '{2'b00, HEADTAIL, HEADTAIL, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1};

        rst = 1'b1;
        credit_valid_i = 1'b0;
        credit_vc_i = '0;
        is_empty_i = '1;
        flit_label_i = '{HEAD, HEAD};
        #1;

        // Reset with a HEADTAIL waiting on VC0, then confirm VC0 has 7 credits left.
        apply_reset(1'b1);
        step(1'b0, 0, got);
        check("t1_first_grant", got, 0);
        for (int i = 0; i < 10; i++) q0.push_back(HEADTAIL);
        grants = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, got);
            if (got == 0) grants++;
        end
        check("t1_remaining_credits", grants, 7);

        // Table of raw input patterns.
        apply_reset(1'b0);
        foreach (tbl[i]) begin
            is_empty_i      = tbl[i].empty;
            flit_label_i[0] = tbl[i].lab0;
            flit_label_i[1] = tbl[i].lab1;
            credit_valid_i  = tbl[i].cv;
            credit_vc_i     = tbl[i].cvc;
            #1;
            check($sformatf("tbl%0d_read", i), read_o, tbl[i].exp_read);
            check($sformatf("tbl%0d_valid", i), valid_o, |tbl[i].exp_read);
            check($sformatf("tbl%0d_sel", i), vc_sel_o, tbl[i].exp_sel);
            check($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
            @(posedge clk);
            #1;
        end
        is_empty_i = '1;
        credit_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("err_sticky", err_o, 1);
        end

        // Locked packet on VC0 must finish before VC1's packet starts, back to back.
        apply_reset(1'b0);
        push_packet(0, 1);
        push_packet(1, 0);
        order = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, got);
            check($sformatf("t2_order%0d", i), got, order[i]);
        end
        check("t2_err", err_o, 0);

        // Credit exhaustion and single credit return.
        apply_reset(1'b0);
        push_packet(0, 30);
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0, got);
            if (got == 0) grants++;
        end
        check("t4_grants", grants, 8);
        step(1'b1, 0, got);
        check("t4_no_same_cycle", got, -1);
        step(1'b0, 0, got);
        check("t4_one_more", got, 0);
        step(1'b0, 0, got);
        check("t4_stall_again", got, -1);
        check("t4_err", err_o, 0);

        // Credit overflow is dropped and flagged.
        apply_reset(1'b0);
        step(1'b1, 0, got);
        step(1'b0, 0, got);
        check("t6_overflow_err", err_o, 1);
        for (int i = 0; i < 12; i++) q0.push_back(HEADTAIL);
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0, got);
            if (got == 0) grants++;
        end
        check("t6_cred_stays_8", grants, 8);

        // Grant plus credit return on the same VC leaves the count unchanged.
        apply_reset(1'b0);
        for (int i = 0; i < 12; i++) q0.push_back(HEADTAIL);
        step(1'b1, 0, got);
        check("t6_same_cycle_grant", got, 0);
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0, got);
            if (got == 0) grants++;
        end
        check("t6_net_unchanged", grants, 8);
        check("t6_no_err", err_o, 0);

        // Randomized traffic with periodic mid-packet resets.
        apply_reset(1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (q_size(v) < 3 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 99) == 0) q_push(v, flit_label_t'($urandom_range(0, 3)));
                    else push_packet(v, int'($urandom_range(0, 4)) - 1);
                end
            end
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 1)), got);
            if (cyc % 500 == 499) apply_reset(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
